// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and controller state encoding for the image controller.
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRTBK   = 4'd0;
    localparam logic [3:0] CMD_UP      = 4'd1;
    localparam logic [3:0] CMD_DN      = 4'd2;
    localparam logic [3:0] CMD_LF      = 4'd3;
    localparam logic [3:0] CMD_RT      = 4'd4;
    localparam logic [3:0] CMD_AVG     = 4'd5;
    localparam logic [3:0] CMD_MRR_X   = 4'd6;
    localparam logic [3:0] CMD_MRR_Y   = 4'd7;
    localparam logic [3:0] CMD_MAX     = 4'd8;
    localparam logic [3:0] CMD_MIN     = 4'd9;
    localparam logic [3:0] CMD_ROT_CW  = 4'd10;
    localparam logic [3:0] CMD_ROT_CCW = 4'd11;
    localparam logic [3:0] CMD_CENTER  = 4'd12;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_IDLE,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: produces the new P1..P4 for one command.
// Every output is derived from the pre-command pixels, so updates are simultaneous.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [3:0]       cmd,
    input  logic [PIX_W-1:0] p1,
    input  logic [PIX_W-1:0] p2,
    input  logic [PIX_W-1:0] p3,
    input  logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] n1,
    output logic [PIX_W-1:0] n2,
    output logic [PIX_W-1:0] n3,
    output logic [PIX_W-1:0] n4,
    output logic             we
);

    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] avg;
    logic [PIX_W-1:0] max12, max34, max_all;
    logic [PIX_W-1:0] min12, min34, min_all;

    // Two extra bits keep the four-pixel sum exact before the floor divide
    assign sum     = {2'b00, p1} + {2'b00, p2} + {2'b00, p3} + {2'b00, p4};
    assign avg     = PIX_W'(sum >> 2);
    assign max12   = (p1 > p2) ? p1 : p2;
    assign max34   = (p3 > p4) ? p3 : p4;
    assign max_all = (max12 > max34) ? max12 : max34;
    assign min12   = (p1 < p2) ? p1 : p2;
    assign min34   = (p3 < p4) ? p3 : p4;
    assign min_all = (min12 < min34) ? min12 : min34;

    // Select new window contents; non-pixel commands leave the window untouched
    always_comb begin
        n1 = p1;
        n2 = p2;
        n3 = p3;
        n4 = p4;
        we = 1'b0;
        case (cmd)
            CMD_AVG: begin
                n1 = avg; n2 = avg; n3 = avg; n4 = avg; we = 1'b1;
            end
            CMD_MRR_X: begin
                n1 = p3; n2 = p4; n3 = p1; n4 = p2; we = 1'b1;
            end
            CMD_MRR_Y: begin
                n1 = p2; n2 = p1; n3 = p4; n4 = p3; we = 1'b1;
            end
            CMD_MAX: begin
                n1 = max_all; n2 = max_all; n3 = max_all; n4 = max_all; we = 1'b1;
            end
            CMD_MIN: begin
                n1 = min_all; n2 = min_all; n3 = min_all; n4 = min_all; we = 1'b1;
            end
            CMD_ROT_CW: begin
                n1 = p3; n2 = p1; n4 = p2; n3 = p4; we = 1'b1;
            end
            CMD_ROT_CCW: begin
                n1 = p2; n2 = p4; n4 = p3; n3 = p1; we = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised image controller: loads the image from ROM, edits a 2x2 window
// around a movable operation point, and streams the image to the RAM buffer.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_LOAD  | read ROM 0..N-1 into storage, data captured one edge late
//   ST_IDLE  | accept a command
//   ST_EXEC  | apply the latched command (single cycle)
//   ST_WRITE | stream storage to the buffer, ascending addresses
//   ST_DONE  | write-back complete, waits for reset
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PIX_W-1:0]  IROM_Q,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    output logic              IROM_EN,
    output logic [ADDR_W-1:0] IROM_A,
    output logic              IRB_RW,
    output logic [PIX_W-1:0]  IRB_D,
    output logic [ADDR_W-1:0] IRB_A,
    output logic              busy,
    output logic              done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(N - 1);
    localparam logic [XW-1:0]     X_HOME = XW'(IMG_W / 2);
    localparam logic [XW-1:0]     X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_HOME = YW'(IMG_H / 2);
    localparam logic [YW-1:0]     Y_MAX  = YW'(IMG_H - 1);

    state_t            state, state_nxt;
    logic [3:0]        cmd_q;
    logic              accept;
    logic [XW-1:0]     op_x, x_lf;
    logic [YW-1:0]     op_y, y_up;
    logic [ADDR_W-1:0] a1, a2, a3, a4;
    logic [PIX_W-1:0]  img [N];
    logic [PIX_W-1:0]  n1, n2, n3, n4;
    logic              alu_we;

    assign accept = (state == ST_IDLE) && cmd_valid;

    // Widths are powers of two, so y*IMG_W+x is a plain concatenation
    assign x_lf = op_x - XW'(1);
    assign y_up = op_y - YW'(1);
    assign a1   = {y_up, x_lf};
    assign a2   = {y_up, op_x};
    assign a3   = {op_y, x_lf};
    assign a4   = {op_y, op_x};

    lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
        .cmd (cmd_q),
        .p1  (img[a1]),
        .p2  (img[a2]),
        .p3  (img[a3]),
        .p4  (img[a4]),
        .n1  (n1),
        .n2  (n2),
        .n3  (n3),
        .n4  (n4),
        .we  (alu_we)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_LOAD;
        else       state <= state_nxt;
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_LOAD:  if (!IROM_EN && IROM_A == LAST_A) state_nxt = ST_IDLE;
            ST_IDLE: begin
                busy = 1'b0;
                if (cmd_valid) state_nxt = (cmd == CMD_WRTBK) ? ST_WRITE : ST_EXEC;
            end
            ST_EXEC:  state_nxt = ST_IDLE;
            ST_WRITE: if (IRB_A == LAST_A) state_nxt = ST_DONE;
            ST_DONE: begin
                busy = 1'b0;
                done = 1'b1;
            end
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // ROM address sweep and registered buffer write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IROM_EN <= 1'b1;
            IROM_A  <= '0;
            IRB_RW  <= 1'b1;
            IRB_A   <= '0;
            IRB_D   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (IROM_EN)               IROM_EN <= 1'b0;
                    else if (IROM_A == LAST_A) IROM_EN <= 1'b1;
                    else                       IROM_A  <= IROM_A + ADDR_W'(1);
                end
                ST_IDLE: begin
                    if (accept && cmd == CMD_WRTBK) begin
                        IRB_RW <= 1'b0;
                        IRB_A  <= '0;
                        IRB_D  <= img[0];
                    end
                end
                ST_WRITE: begin
                    if (IRB_A == LAST_A) begin
                        IRB_RW <= 1'b1;
                    end else begin
                        IRB_A <= IRB_A + ADDR_W'(1);
                        IRB_D <= img[IRB_A + ADDR_W'(1)];
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel storage; never cleared, a new LOAD overwrites every location
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && !IROM_EN) img[IROM_A] <= IROM_Q;
        if (state == ST_EXEC && alu_we) begin
            img[a1] <= n1;
            img[a2] <= n2;
            img[a3] <= n3;
            img[a4] <= n4;
        end
    end

    // Command latch and operation-point moves with saturation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q <= CMD_WRTBK;
            op_x  <= X_HOME;
            op_y  <= Y_HOME;
        end else begin
            if (accept) cmd_q <= cmd;
            if (state == ST_EXEC) begin
                case (cmd_q)
                    CMD_UP:     if (op_y != YW'(1)) op_y <= op_y - YW'(1);
                    CMD_DN:     if (op_y != Y_MAX)  op_y <= op_y + YW'(1);
                    CMD_LF:     if (op_x != XW'(1)) op_x <= op_x - XW'(1);
                    CMD_RT:     if (op_x != X_MAX)  op_x <= op_x + XW'(1);
                    CMD_CENTER: begin
                        op_x <= X_HOME;
                        op_y <= Y_HOME;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: an 8x8 instance driven through command scenarios
// against a behavioural image model, plus a 16x4 / 10-bit instance for a plain dump.
module tb_lcd_ctrl_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8x8, 8-bit instance
    logic       rst0, cv0, en0, rw0, busy0, done0;
    logic [3:0] cmd0;
    logic [7:0] q0d, d0;
    logic [5:0] ia0, a0;

    // 16x4, 10-bit instance
    logic       rst1, cv1, en1, rw1, busy1, done1;
    logic [3:0] cmd1;
    logic [9:0] q1d, d1;
    logic [5:0] ia1, a1;

    function automatic int rom1(int i);
        return (i * 13 + 5) % 1024;
    endfunction

    assign q0d = 8'(ia0);
    assign q1d = 10'(rom1(int'(ia1)));

    lcd_ctrl_param #(.IMG_W(8), .IMG_H(8), .PIX_W(8), .ADDR_W(6)) dut0 (
        .clk(clk), .reset(rst0), .IROM_Q(q0d), .cmd(cmd0), .cmd_valid(cv0),
        .IROM_EN(en0), .IROM_A(ia0), .IRB_RW(rw0), .IRB_D(d0), .IRB_A(a0),
        .busy(busy0), .done(done0)
    );

    lcd_ctrl_param #(.IMG_W(16), .IMG_H(4), .PIX_W(10), .ADDR_W(6)) dut1 (
        .clk(clk), .reset(rst1), .IROM_Q(q1d), .cmd(cmd1), .cmd_valid(cv1),
        .IROM_EN(en1), .IROM_A(ia1), .IRB_RW(rw1), .IRB_D(d1), .IRB_A(a1),
        .busy(busy1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboards: expected (addr, data) pushed before write-back, popped per buffer write
    int qa0[$], qd0[$], qa1[$], qd1[$];
    int wr0 = 0, extra0 = 0, wr1 = 0, extra1 = 0;
    int ea0, ed0, ea1, ed1;

    always @(negedge clk) begin
        if (rst0 === 1'b0 && rw0 === 1'b0) begin
            wr0++;
            if (qa0.size() == 0) extra0++;
            else begin
                ea0 = qa0.pop_front();
                ed0 = qd0.pop_front();
                chk("wr0_addr", 64'(a0), 64'(ea0));
                chk("wr0_data", 64'(d0), 64'(ed0));
            end
        end
    end

    always @(negedge clk) begin
        if (rst1 === 1'b0 && rw1 === 1'b0) begin
            wr1++;
            if (qa1.size() == 0) extra1++;
            else begin
                ea1 = qa1.pop_front();
                ed1 = qd1.pop_front();
                chk("wr1_addr", 64'(a1), 64'(ea1));
                chk("wr1_data", 64'(d1), 64'(ed1));
            end
        end
    end

    // Behavioural model of the 8x8 image and operation point
    int m_img[64];
    int mx, my;

    task automatic m_apply(input int c);
        int i1, i2, i3, i4, v1, v2, v3, v4, t;
        i1 = (my - 1) * 8 + (mx - 1);
        i2 = i1 + 1;
        i3 = my * 8 + (mx - 1);
        i4 = i3 + 1;
        v1 = m_img[i1]; v2 = m_img[i2]; v3 = m_img[i3]; v4 = m_img[i4];
        case (c)
            1:  if (my > 1) my--;
            2:  if (my < 7) my++;
            3:  if (mx > 1) mx--;
            4:  if (mx < 7) mx++;
            5:  begin
                t = (v1 + v2 + v3 + v4) / 4;
                m_img[i1] = t; m_img[i2] = t; m_img[i3] = t; m_img[i4] = t;
            end
            6:  begin m_img[i1] = v3; m_img[i2] = v4; m_img[i3] = v1; m_img[i4] = v2; end
            7:  begin m_img[i1] = v2; m_img[i2] = v1; m_img[i3] = v4; m_img[i4] = v3; end
            8:  begin
                t = v1;
                if (v2 > t) t = v2;
                if (v3 > t) t = v3;
                if (v4 > t) t = v4;
                m_img[i1] = t; m_img[i2] = t; m_img[i3] = t; m_img[i4] = t;
            end
            9:  begin
                t = v1;
                if (v2 < t) t = v2;
                if (v3 < t) t = v3;
                if (v4 < t) t = v4;
                m_img[i1] = t; m_img[i2] = t; m_img[i3] = t; m_img[i4] = t;
            end
            10: begin m_img[i1] = v3; m_img[i2] = v1; m_img[i4] = v2; m_img[i3] = v4; end
            11: begin m_img[i1] = v2; m_img[i2] = v4; m_img[i4] = v3; m_img[i3] = v1; end
            12: begin mx = 4; my = 4; end
            default: ;
        endcase
    endtask

    // Assert reset right away, check reset values, release, and time the load
    task automatic rst_dut0(input logic hold_up);
        int n;
        rst0 = 1'b1;
        cv0  = hold_up;
        cmd0 = hold_up ? 4'd1 : 4'd0;
        @(negedge clk);
        chk("rst_en",   64'(en0),   64'd1);
        chk("rst_roma", 64'(ia0),   64'd0);
        chk("rst_rw",   64'(rw0),   64'd1);
        chk("rst_irba", 64'(a0),    64'd0);
        chk("rst_irbd", 64'(d0),    64'd0);
        chk("rst_busy", 64'(busy0), 64'd1);
        chk("rst_done", 64'(done0), 64'd0);
        qa0.delete();
        qd0.delete();
        for (int i = 0; i < 64; i++) m_img[i] = i;
        mx = 4;
        my = 4;
        rst0 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("ld_en", 64'(en0), 64'd0);
                chk("ld_a0", 64'(ia0), 64'd0);
            end
            if (n == 2) chk("ld_a1", 64'(ia0), 64'd1);
        end while (busy0 && n < 200);
        chk("load_len", 64'(n), 64'd65);
        chk("ld_done", 64'(done0), 64'd0);
    endtask

    // Issue one non-write-back command from IDLE and check the 2-edge busy pulse
    task automatic send0(input int c);
        cmd0 = 4'(c);
        cv0  = 1'b1;
        @(negedge clk);
        cv0 = 1'b0;
        chk("busy_acc", 64'(busy0), 64'd1);
        @(negedge clk);
        chk("busy_exec", 64'(busy0), 64'd0);
        m_apply(c);
    endtask

    // Write back the image and compare every buffer write against the model
    task automatic dump0();
        int n;
        wr0 = 0;
        for (int i = 0; i < 64; i++) begin
            qa0.push_back(i);
            qd0.push_back(m_img[i]);
        end
        cmd0 = 4'd0;
        cv0  = 1'b1;
        @(negedge clk);
        cv0 = 1'b0;
        n = 0;
        while (!done0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("wb_done", 64'(done0), 64'd1);
        chk("wb_cnt",  64'(wr0),   64'd64);
        chk("wb_left", 64'(qa0.size()), 64'd0);
    endtask

    initial begin
        int n;
        rst1 = 1'b1;
        cv1  = 1'b0;
        cmd1 = 4'd0;

        // Identity write-back, then done must hold with commands ignored
        rst_dut0(1'b0);
        dump0();
        cmd0 = 4'd1;
        cv0  = 1'b1;
        repeat (6) @(negedge clk);
        cv0 = 1'b0;
        chk("done_hold", 64'(done0), 64'd1);
        chk("done_busy", 64'(busy0), 64'd0);
        chk("done_nowr", 64'(extra0), 64'd0);

        // Window operators at the home point
        rst_dut0(1'b0); send0(5);  dump0();
        rst_dut0(1'b0); send0(8);  dump0();
        rst_dut0(1'b0); send0(9);  dump0();
        rst_dut0(1'b0); send0(10); dump0();
        rst_dut0(1'b0); send0(10); send0(11); dump0();
        rst_dut0(1'b0); send0(4);  send0(6); send0(7); dump0();

        // Saturation at both corners, then re-centre
        rst_dut0(1'b0);
        repeat (5) send0(2);
        repeat (5) send0(4);
        send0(8);
        repeat (7) send0(1);
        repeat (7) send0(3);
        send0(5);
        send0(12);
        send0(5);
        dump0();

        // UP held through LOAD and EXEC moves the point only once
        rst_dut0(1'b1);
        @(negedge clk);
        chk("hold_acc", 64'(busy0), 64'd1);
        @(negedge clk);
        chk("hold_exec", 64'(busy0), 64'd0);
        cv0 = 1'b0;
        m_apply(1);
        send0(5);
        dump0();

        // Random command mix including no-op codes
        rst_dut0(1'b0);
        repeat (30) send0(int'($urandom_range(15, 1)));
        dump0();

        // Reset during write-back at buffer address 20
        rst_dut0(1'b0);
        cmd0 = 4'd0;
        cv0  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            qa0.push_back(i);
            qd0.push_back(m_img[i]);
        end
        @(negedge clk);
        cv0 = 1'b0;
        n = 0;
        while (!(rw0 === 1'b0 && a0 == 6'd20) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_at20", 64'(a0), 64'd20);
        #1;
        rst_dut0(1'b0);
        dump0();

        // 16x4, 10-bit instance: load timing and full dump
        @(negedge clk);
        chk("r1_en",   64'(en1),   64'd1);
        chk("r1_busy", 64'(busy1), 64'd1);
        chk("r1_done", 64'(done1), 64'd0);
        rst1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy1 && n < 200);
        chk("r1_load_len", 64'(n), 64'd65);
        wr1 = 0;
        for (int i = 0; i < 64; i++) begin
            qa1.push_back(i);
            qd1.push_back(rom1(i));
        end
        cmd1 = 4'd0;
        cv1  = 1'b1;
        @(negedge clk);
        cv1 = 1'b0;
        n = 0;
        while (!done1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("r1_done_end", 64'(done1), 64'd1);
        chk("r1_wb_cnt",   64'(wr1),   64'd64);
        chk("r1_wb_left",  64'(qa1.size()), 64'd0);

        chk("extra0", 64'(extra0), 64'd0);
        chk("extra1", 64'(extra1), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised image controller, the successor to the fixed 8x8 LCD controller.
- Loads an IMG_W x IMG_H image of PIX_W-bit pixels from the image ROM into internal storage.
- Applies host commands to a 2x2 window around a movable operation point.
- On write-back, streams the whole image to the image RAM buffer, then raises done.
- Adds MAX/MIN, rotate CW/CCW and re-centre commands, and a 4-bit command field.

Parameters:
IMG_W, 8, image width in pixels; power of two, >=4
IMG_H, 8, image height in pixels; power of two, >=4
PIX_W, 8, pixel width in bits
ADDR_W, 6, address width; must equal log2(IMG_W*IMG_H)

Ports:
clk  in  1  single clock; all state changes on posedge
reset  in  1  asynchronous, active-high reset
IROM_Q  in  PIX_W  ROM read data; valid one cycle after IROM_A while IROM_EN=0
cmd  in  4  command code
cmd_valid  in  1  command strobe; accepted only when busy=0
IROM_EN  out  1  ROM enable, active-low
IROM_A  out  ADDR_W  ROM address
IRB_RW  out  1  1=read/idle, 0=write
IRB_D  out  PIX_W  buffer write data
IRB_A  out  ADDR_W  buffer address
busy  out  1  controller not accepting commands
done  out  1  write-back complete; sticky until reset

Behaviour:
- Reset values:
  - outputs: IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, busy=1, done=0.
  - op point: opX=IMG_W/2, opY=IMG_H/2.
  - state: LOAD.
- Addressing: pixel (x,y) lives at address y*IMG_W+x.
- Window around op point (opX,opY), with opX in 1..IMG_W-1 and opY in 1..IMG_H-1:
  - P1 at (opX-1,opY-1), P2 at (opX,opY-1), P3 at (opX-1,opY), P4 at (opX,opY).
- State LOAD:
  - IROM_EN=0; IROM_A counts 0..N-1, where N=IMG_W*IMG_H.
  - IROM_Q is stored one cycle after its address, so the last pixel is stored at edge N+1.
  - Then IROM_EN=1, busy=0, go to IDLE.
- State IDLE (busy=0): cmd_valid=1 accepts cmd at that edge.
  - WRTBK(0) -> WRITE.
  - Any other code -> EXEC.
- State EXEC (busy=1, exactly one cycle):
  - Apply the command at the end of the cycle, then return to IDLE.
  - Latency: accept-to-busy-low is 2 edges.
- Commands:
  - UP(1), DN(2), LF(3), RT(4): move op point by 1; saturate at 1 / IMG_H-1 / 1 / IMG_W-1; no wrap.
  - AVG(5): all four pixels get (P1+P2+P3+P4)>>2, summed in PIX_W+2 bits and truncated (floor).
  - MRR_X(6): swap the top and bottom rows of the window.
  - MRR_Y(7): swap the left and right columns of the window.
  - MAX(8): all four pixels get max(P1..P4).
  - MIN(9): all four pixels get min(P1..P4).
  - ROT_CW(10): P1<-P3, P2<-P1, P4<-P2, P3<-P4.
  - ROT_CCW(11): P1<-P2, P2<-P4, P4<-P3, P3<-P1.
  - CENTER(12): op point returns to its reset value.
  - Codes 13-15: no-op; EXEC still takes one cycle.
- All four window updates in one command use pre-command values, i.e. they are simultaneous.
- State WRITE (busy=1):
  - IRB_RW=0; IRB_A/IRB_D are registered and sweep 0..N-1, one pixel per cycle, ascending.
  - After pixel N-1: IRB_RW=1, go to DONE.
- State DONE: done=1, busy=0, cmd_valid ignored; leaves only on reset.
- Ignored inputs: cmd_valid while busy=1 has no effect and is not queued.
- Reset in any state, including mid-LOAD or mid-WRITE, restarts LOAD from address 0. Image contents are not cleared but are fully overwritten.

Decomposition:
- Package lcd_ctrl_pkg:
  - 4-bit command code constants.
  - State encoding: LOAD, IDLE, EXEC, WRITE, DONE.
- Sub-module lcd_win_alu: combinational. Takes P1..P4 and cmd; returns the four new pixels plus write-enable. Covers the AVG/MAX/MIN/mirror/rotate logic.
- Top level holds the FSM, counters, op point and pixel storage.

Test Plan:
- Default 8x8, ROM pixel[i]=i; reset, then WRTBK:
  - busy=1 for 65 cycles after reset.
  - IRB writes addr i with data i for i=0..63, IRB_RW=0 for exactly 64 cycles.
  - done=1 afterwards and remains 1.
- AVG at op (4,4), window addrs 27,28,35,36: all four become 31. MAX instead: all become 36. MIN instead: all become 27. Check each via WRTBK dump.
- ROT_CW at (4,4): addr27=35, addr28=27, addr36=28, addr35=36. ROT_CCW then restores the original image.
- UP x5 then LF x5: op saturates at (1,1). AVG then affects addrs 0,1,8,9 -> value (0+1+8+9)>>2=4. CENTER then AVG affects addrs 27,28,35,36.
- cmd_valid with UP held during the EXEC cycle and during LOAD: ignored, op moves by only 1. cmd_valid after done: no IRB activity.
- Reset asserted at WRITE address 20: IROM_EN=0 immediately after release, IROM_A restarts at 0, done stays 0. Repeat the first scenario with IMG_W=16, IMG_H=4, ADDR_W=6, PIX_W=10.
